data_memory_write_interface: RTL and testbench
==============================================

DATA_MEMORY_WRITE_INTERFACE -- requirements
Module: data_memory_write_interface

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 16, the width of the misaligned-store counter.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: a store request is present from the memory stage.
REQ-005 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have port store_type, input, 3 bits: RISC-V funct3; 000 sb, 001 sh, 010 sw, other values reserved.
REQ-007 SHALL have port st_addr, input, word: the byte address (ALU output).
REQ-008 SHALL have port st_data, input, word: the rs2 value, with the least significant bytes significant.
REQ-009 SHALL have port mem_wr_valid, output, 1 bit: a memory write beat is presented.
REQ-010 SHALL have port mem_wr_ready, input, 1 bit: data memory accepts the beat.
REQ-011 SHALL have port mem_wr_addr, output, 30 bits: the word index (byte address >> 2).
REQ-012 SHALL have port mem_byte_en, output, 4 bits: per-byte write enables; bit i covers bits 8i+7..8i.
REQ-013 SHALL have port mem_wr_data, output, word: the lane-aligned write data.
REQ-014 SHALL have port st_done, output, 1 bit: a one-cycle pulse marking store completion.
REQ-015 SHALL have port st_error, output, 1 bit: a one-cycle pulse marking a reserved store_type.
REQ-016 SHALL have port misaligned_count, output, COUNT_WIDTH bits: the number of split stores, saturating.

Function
REQ-017 SHALL implement the FSM states IDLE, BEAT0 and BEAT1; req_ready=1 only in IDLE.
REQ-018 SHALL accept a request on req_valid&req_ready and latch the address, data and type; mem_wr_valid rises the following cycle (latency 1).
REQ-019 SHALL use size mask 0001 (sb), 0011 (sh), 1111 (sw); with off=st_addr[1:0], wide=mask<<off (7 bits) and shifted data=st_data<<(8*off) (64 bits).
REQ-020 SHALL drive beat 0 as addr=st_addr[31:2], byte_en=wide[3:0], data=shifted[31:0].
REQ-021 SHALL treat a store as split when wide[6:4]!=0; beat 1 is then addr=st_addr[31:2]+1 (modulo 2^30, so 0x3FFFFFFF wraps to 0), byte_en={1'b0,wide[6:4]}, data=shifted[63:32].
REQ-022 SHALL move BEAT0 to BEAT1 on mem_wr_ready when the store is split, otherwise to IDLE; SHALL move BEAT1 to IDLE on mem_wr_ready.
REQ-023 SHALL hold mem_wr_addr, mem_byte_en and mem_wr_data stable while mem_wr_valid=1 and mem_wr_ready=0.
REQ-024 SHALL pulse st_done in the cycle of the final beat handshake.
REQ-025 SHALL not write memory on a reserved store_type: the request is accepted, st_error pulses the next cycle, and the FSM stays in IDLE.
REQ-026 SHALL increment misaligned_count at acceptance of each split store and hold it at all-ones.
REQ-027 SHALL drive mem_byte_en=0000 and mem_wr_data=0 while mem_wr_valid=0.
REQ-028 SHALL ignore req_valid outside IDLE; the upstream holds its request.

Reset
REQ-029 SHALL, while reset=1 at a rising edge, set the state to IDLE, misaligned_count to 0, and mem_wr_valid, st_done and st_error to 0; req_ready=1 from the following cycle.
REQ-030 SHALL, on reset mid-store (BEAT0 or BEAT1), abandon the pending beats; a half-written split store is not completed and no st_done is issued.

Structure
REQ-031 SHALL take word, the store_type encodings (SB/SH/SW) and the FSM state enum from the common definitions header shared by all stages.
REQ-032 SHALL place lane alignment (REQ-019 to REQ-021) in the combinational sub-module store_lane_align; the FSM, latches and counter stay in the top.

Verification
REQ-033 SHALL cover: sw, addr 0x00000100, data 0xDEADBEEF, mem_wr_ready=1 -> one beat: addr 0x40, be 1111, data 0xDEADBEEF; st_done the same cycle.
REQ-034 SHALL cover: sb, addr 0x00000103, data 0x000000A5 -> addr 0x40, be 1000, data 0xA5000000; misaligned_count unchanged.
REQ-035 SHALL cover: sw, addr 0x00000106, data 0x11223344 -> beat 0: addr 0x41, be 1100, data 0x33440000; beat 1: addr 0x42, be 0011, data 0x00001122; misaligned_count=1.
REQ-036 SHALL cover: sh, addr 0xFFFFFFFF, data 0xBEEF, mem_wr_ready low 3 cycles -> beat 0 held stable (addr 0x3FFFFFFF, be 1000, data 0xEF000000); beat 1: addr 0x0, be 0001, data 0x000000BE.
REQ-037 SHALL cover: store_type 011 -> no mem_wr_valid, st_error pulses once, req_ready stays 1.
REQ-038 SHALL cover: reset asserted in BEAT1 -> mem_wr_valid 0 after the edge, no st_done, count 0, the next sw completes normally.

Source files
------------

// File: rtl/data_memory_write_interface_pkg.sv
// Shared store-path definitions: word type, RISC-V store funct3 encodings,
// write FSM states and the per-size byte mask.
package data_memory_write_interface_pkg;

  typedef logic [31:0] word;

  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } wr_state_e;

  // Unaligned byte mask for a store size; reserved types give an empty mask.
  function automatic logic [3:0] size_mask(input logic [2:0] store_type);
    case (store_type)
      ST_SB:   return 4'b0001;
      ST_SH:   return 4'b0011;
      ST_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_write_interface_store_lane_align.sv
// Combinational lane alignment: turns a byte address/data/size into one or two
// word-aligned write beats.
module store_lane_align
  import data_memory_write_interface_pkg::*;
(
  input  logic [2:0]  store_type,
  input  word         st_addr,
  input  word         st_data,
  output logic [29:0] beat0_addr,
  output logic [3:0]  beat0_be,
  output word         beat0_data,
  output logic [29:0] beat1_addr,
  output logic [3:0]  beat1_be,
  output word         beat1_data,
  output logic        split,
  output logic        reserved
);

  logic [1:0]  off;
  logic [6:0]  wide;
  logic [63:0] shifted;

  assign off     = st_addr[1:0];
  assign wide    = {3'b000, size_mask(store_type)} << off;
  assign shifted = {32'h0, st_data} << {off, 3'b000};

  assign beat0_addr = st_addr[31:2];
  assign beat0_be   = wide[3:0];
  assign beat0_data = shifted[31:0];

  // The upper word index wraps naturally at 30 bits.
  assign beat1_addr = st_addr[31:2] + 30'd1;
  assign beat1_be   = {1'b0, wide[6:4]};
  assign beat1_data = shifted[63:32];

  assign split    = |wide[6:4];
  assign reserved = (store_type != ST_SB) && (store_type != ST_SH) && (store_type != ST_SW);

endmodule

// File: rtl/data_memory_write_interface.sv
// Store write port: accepts a store from the memory stage and issues one or two
// byte-enabled word beats to data memory, counting misaligned (split) stores.
module data_memory_write_interface
  import data_memory_write_interface_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             store_type,
  input  word                    st_addr,
  input  word                    st_data,
  output logic                   mem_wr_valid,
  input  logic                   mem_wr_ready,
  output logic [29:0]            mem_wr_addr,
  output logic [3:0]             mem_byte_en,
  output word                    mem_wr_data,
  output logic                   st_done,
  output logic                   st_error,
  output logic [COUNT_WIDTH-1:0] misaligned_count
);

  wr_state_e              state_reg;
  logic                   valid_reg;
  logic [29:0]            addr_reg;
  logic [3:0]             be_reg;
  word                    data_reg;
  logic [29:0]            b1_addr_reg;
  logic [3:0]             b1_be_reg;
  word                    b1_data_reg;
  logic                   split_reg;
  logic                   error_reg;
  logic [COUNT_WIDTH-1:0] count_reg;

  logic [29:0] a0_addr, a1_addr;
  logic [3:0]  a0_be, a1_be;
  word         a0_data, a1_data;
  logic        a_split, a_reserved;

  store_lane_align u_align (
    .store_type (store_type),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .beat0_addr (a0_addr),
    .beat0_be   (a0_be),
    .beat0_data (a0_data),
    .beat1_addr (a1_addr),
    .beat1_be   (a1_be),
    .beat1_data (a1_data),
    .split      (a_split),
    .reserved   (a_reserved)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      valid_reg   <= 1'b0;
      addr_reg    <= '0;
      be_reg      <= '0;
      data_reg    <= '0;
      b1_addr_reg <= '0;
      b1_be_reg   <= '0;
      b1_data_reg <= '0;
      split_reg   <= 1'b0;
      error_reg   <= 1'b0;
      count_reg   <= '0;
    end else begin
      error_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (a_reserved) begin
              error_reg <= 1'b1;
            end else begin
              // Both beats are aligned now so the request inputs can move on.
              state_reg   <= BEAT0;
              valid_reg   <= 1'b1;
              addr_reg    <= a0_addr;
              be_reg      <= a0_be;
              data_reg    <= a0_data;
              b1_addr_reg <= a1_addr;
              b1_be_reg   <= a1_be;
              b1_data_reg <= a1_data;
              split_reg   <= a_split;
              if (a_split && !(&count_reg))
                count_reg <= count_reg + COUNT_WIDTH'(1);
            end
          end
        end
        BEAT0: begin
          if (mem_wr_ready) begin
            if (split_reg) begin
              state_reg <= BEAT1;
              addr_reg  <= b1_addr_reg;
              be_reg    <= b1_be_reg;
              data_reg  <= b1_data_reg;
            end else begin
              state_reg <= IDLE;
              valid_reg <= 1'b0;
              addr_reg  <= '0;
              be_reg    <= '0;
              data_reg  <= '0;
            end
          end
        end
        BEAT1: begin
          if (mem_wr_ready) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            be_reg    <= '0;
            data_reg  <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready        = (state_reg == IDLE);
  assign mem_wr_valid     = valid_reg;
  assign mem_wr_addr      = addr_reg;
  assign mem_byte_en      = be_reg;
  assign mem_wr_data      = data_reg;
  assign st_error         = error_reg;
  assign misaligned_count = count_reg;

  // Completion coincides with the handshake of the last beat.
  assign st_done = valid_reg && mem_wr_ready &&
                   ((state_reg == BEAT1) || (state_reg == BEAT0 && !split_reg));

endmodule

// File: tb/tb_data_memory_write_interface.sv
// Directed bench for the store write port: aligned, byte, split, stalled/wrapping,
// reserved-type and mid-store reset cases with hand-computed expectations.
module tb_data_memory_write_interface;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  store_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [29:0] mem_wr_addr;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wr_data;
  logic        st_done;
  logic        st_error;
  logic [15:0] misaligned_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  data_memory_write_interface #(.COUNT_WIDTH(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .store_type       (store_type),
    .st_addr          (st_addr),
    .st_data          (st_data),
    .mem_wr_valid     (mem_wr_valid),
    .mem_wr_ready     (mem_wr_ready),
    .mem_wr_addr      (mem_wr_addr),
    .mem_byte_en      (mem_byte_en),
    .mem_wr_data      (mem_wr_data),
    .st_done          (st_done),
    .st_error         (st_error),
    .misaligned_count (misaligned_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle; returns at the negedge after acceptance.
  task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    req_valid  = 1'b1;
    store_type = t;
    st_addr    = a;
    st_data    = d;
    #1;
    check("issue.req_ready", req_ready, 1);
    @(negedge clock);
    req_valid = 1'b0;
    $display("req type=%0b addr=0x%08h data=0x%08h", t, a, d);
  endtask

  // Check the beat currently on the bus (called just after a negedge).
  task automatic check_beat(input string tag, input logic [29:0] a, input logic [3:0] be,
                            input logic [31:0] d, input logic done);
    #1;
    check({tag, ".valid"}, mem_wr_valid, 1);
    check({tag, ".addr"},  mem_wr_addr, a);
    check({tag, ".be"},    mem_byte_en, be);
    check({tag, ".data"},  mem_wr_data, d);
    check({tag, ".done"},  st_done, done);
    check({tag, ".ready"}, req_ready, 0);
    $display("beat %s addr=0x%08h be=%04b data=0x%08h done=%0b", tag, mem_wr_addr,
             mem_byte_en, mem_wr_data, st_done);
  endtask

  task automatic check_idle(input string tag);
    #1;
    check({tag, ".valid"}, mem_wr_valid, 0);
    check({tag, ".be"},    mem_byte_en, 0);
    check({tag, ".data"},  mem_wr_data, 0);
    check({tag, ".done"},  st_done, 0);
    check({tag, ".ready"}, req_ready, 1);
    $display("idle %s", tag);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; store_type = 3'b000;
    st_addr = '0; st_data = '0; mem_wr_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_idle("reset");
    check("reset.count", misaligned_count, 0);
    check("reset.error", st_error, 0);

    // Aligned word
    issue(3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    check_beat("sw_aligned", 30'h40, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    @(negedge clock);
    check_idle("sw_aligned.after");

    // Byte in top lane, not split
    issue(3'b000, 32'h0000_0103, 32'h0000_00A5);
    check_beat("sb_lane3", 30'h40, 4'b1000, 32'hA500_0000, 1'b1);
    check("sb_lane3.count", misaligned_count, 0);
    @(negedge clock);
    check_idle("sb_lane3.after");

    // Split word
    issue(3'b010, 32'h0000_0106, 32'h1122_3344);
    check_beat("sw_split.b0", 30'h41, 4'b1100, 32'h3344_0000, 1'b0);
    check("sw_split.count", misaligned_count, 1);
    @(negedge clock);
    check_beat("sw_split.b1", 30'h42, 4'b0011, 32'h0000_1122, 1'b1);
    @(negedge clock);
    check_idle("sw_split.after");

    // Split halfword at top of address space with back-pressure
    mem_wr_ready = 1'b0;
    issue(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF);
    for (int i = 0; i < 3; i++) begin
      check_beat("sh_wrap.stall", 30'h3FFF_FFFF, 4'b1000, 32'hEF00_0000, 1'b0);
      @(negedge clock);
    end
    mem_wr_ready = 1'b1;
    check_beat("sh_wrap.b0", 30'h3FFF_FFFF, 4'b1000, 32'hEF00_0000, 1'b0);
    @(negedge clock);
    check_beat("sh_wrap.b1", 30'h0, 4'b0001, 32'h0000_00BE, 1'b1);
    check("sh_wrap.count", misaligned_count, 2);
    @(negedge clock);
    check_idle("sh_wrap.after");

    // Reserved store type
    issue(3'b011, 32'h0000_0200, 32'h1234_5678);
    #1;
    check("reserved.error", st_error, 1);
    check_idle("reserved");
    @(negedge clock);
    #1;
    check("reserved.error_clear", st_error, 0);
    check_idle("reserved.after");
    check("reserved.count", misaligned_count, 2);

    // Reset while in the second beat
    issue(3'b010, 32'h0000_0106, 32'h1122_3344);
    check_beat("rst_split.b0", 30'h41, 4'b1100, 32'h3344_0000, 1'b0);
    @(negedge clock);
    mem_wr_ready = 1'b0;
    reset = 1'b1;
    check_beat("rst_split.b1", 30'h42, 4'b0011, 32'h0000_1122, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    mem_wr_ready = 1'b1;
    check_idle("rst_split.after");
    check("rst_split.count", misaligned_count, 0);
    check("rst_split.error", st_error, 0);
    issue(3'b010, 32'h0000_0100, 32'hCAFE_F00D);
    check_beat("post_reset", 30'h40, 4'b1111, 32'hCAFE_F00D, 1'b1);
    @(negedge clock);
    check_idle("post_reset.after");
    check("post_reset.count", misaligned_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
